// File: rtl/buffer_reader.sv
// buffer_reader: assembles DATA_OUT_LEN-bit words from a show-ahead UART RX
// FIFO, DATA_LEN bits at a time, least significant byte first.
//
// Handshakes:
//   FIFO side    - i_rd_data is the FIFO head and is valid whenever
//                  i_is_uart_empty=0. A one-cycle o_uart_rd pulse consumes
//                  that head at the next rising edge. Because the strobe is
//                  never high on two consecutive cycles, the FIFO has always
//                  advanced before the head is sampled again.
//   Request side - i_rd is accepted only in IDLE. Acceptance clears the word.
//                  o_rd_finished then marks o_rd_buffer valid and stable
//                  until the next request is accepted.
module buffer_reader #(
  parameter int DATA_LEN     = 8,
  parameter int DATA_OUT_LEN = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_is_uart_empty,
  input  logic                    i_rd,
  input  logic [DATA_LEN-1:0]     i_rd_data,
  output logic                    o_uart_rd,
  output logic                    o_rd_finished,
  output logic [DATA_OUT_LEN-1:0] o_rd_buffer
);

  // Bytes per word. DATA_OUT_LEN must be an integer multiple of DATA_LEN.
  localparam int NB = DATA_OUT_LEN / DATA_LEN;
  // The pointer runs 0..NB inclusive, so it needs one bit beyond clog2(NB).
  localparam int PW = $clog2(NB) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_IDLE = 2'd1,
    RD      = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [PW-1:0]           r_ptr;
  logic [PW-1:0]           w_ptr_next;
  logic                    r_uart_rd;
  logic                    w_uart_rd_next;
  logic                    r_rd_finished;
  logic                    w_rd_finished_next;
  logic [DATA_OUT_LEN-1:0] r_rd_buffer;
  logic [DATA_OUT_LEN-1:0] w_rd_buffer_next;

  // State, pointer and every output are registered; reset clears them all.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_uart_rd     <= 1'b0;
      r_rd_finished <= 1'b0;
      r_rd_buffer   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_ptr         <= w_ptr_next;
      r_uart_rd     <= w_uart_rd_next;
      r_rd_finished <= w_rd_finished_next;
      r_rd_buffer   <= w_rd_buffer_next;
    end
  end

  // Next state and next output values. The pop strobe defaults low, so it
  // lasts one cycle. Every other output holds its value unless changed here.
  always_comb begin
    w_state_next       = r_state;
    w_ptr_next         = r_ptr;
    w_uart_rd_next     = 1'b0;
    w_rd_finished_next = r_rd_finished;
    w_rd_buffer_next   = r_rd_buffer;
    case (r_state)
      IDLE: begin
        if (i_rd) begin
          w_rd_finished_next = 1'b0;
          w_rd_buffer_next   = '0;
          w_state_next       = RD_IDLE;
        end
      end
      RD_IDLE: begin
        if (r_ptr == PW'(NB)) begin
          w_rd_finished_next = 1'b1;
          w_ptr_next         = '0;
          w_state_next       = IDLE;
        end else if (!i_is_uart_empty) begin
          for (int b = 0; b < NB; b++) begin
            if (r_ptr == PW'(b)) begin
              w_rd_buffer_next[b*DATA_LEN +: DATA_LEN] = i_rd_data;
            end
          end
          w_uart_rd_next = 1'b1;
          w_state_next   = RD;
        end
      end
      RD: begin
        w_ptr_next   = r_ptr + PW'(1);
        w_state_next = RD_IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_uart_rd     = r_uart_rd;
  assign o_rd_finished = r_rd_finished;
  assign o_rd_buffer   = r_rd_buffer;

endmodule

// File: tb/tb_buffer_reader.sv
// Testbench for buffer_reader. A queue stands in for the show-ahead RX FIFO,
// and a byte-level scoreboard predicts each completed word from the bytes
// pushed, packed least significant byte first.
module tb_buffer_reader;

  localparam int DL = 8;
  localparam int OL = 32;
  localparam int NB = OL / DL;

  logic          clk;
  logic          rst_n;
  logic          uart_empty;
  logic          rd;
  logic [DL-1:0] rd_data;
  logic          uart_rd;
  logic          rd_finished;
  logic [OL-1:0] rd_buffer;

  buffer_reader #(.DATA_LEN(DL), .DATA_OUT_LEN(OL)) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_is_uart_empty (uart_empty),
    .i_rd            (rd),
    .i_rd_data       (rd_data),
    .o_uart_rd       (uart_rd),
    .o_rd_finished   (rd_finished),
    .o_rd_buffer     (rd_buffer)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DL-1:0] fifo_q[$];
  logic [DL-1:0] exp_q[$];
  int            pops = 0;
  int            words = 0;
  logic          prev_uart_rd = 1'b0;
  logic          prev_fin = 1'b0;
  logic [OL-1:0] last_word = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo_if();
    uart_empty = (fifo_q.size() == 0);
    rd_data    = (fifo_q.size() != 0) ? fifo_q[0] : DL'($urandom);
  endtask

  task automatic push_byte(input logic [DL-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    update_fifo_if();
  endtask

  // Advance one cycle, observe #1 after the edge, and run the FIFO model
  // and the scoreboard.
  task automatic tick();
    logic [OL-1:0] w;
    @(posedge clk);
    #1;
    check("no_consecutive_pop", {63'd0, prev_uart_rd & uart_rd}, 64'd0);
    if (uart_rd) begin
      pops++;
      check("pop_nonempty", {63'd0, fifo_q.size() != 0}, 64'd1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (rd_finished && !prev_fin) begin
      words++;
      check("bytes_available", {63'd0, exp_q.size() >= NB}, 64'd1);
      w = '0;
      for (int b = 0; b < NB; b++)
        if (exp_q.size() != 0) w[b*DL +: DL] = exp_q.pop_front();
      last_word = w;
      check("word", rd_buffer, w);
    end
    prev_uart_rd = uart_rd;
    prev_fin     = rd_finished;
    update_fifo_if();
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic wait_finish(input int budget);
    int   w0;
    logic got;
    w0  = words;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (words != w0) got = 1'b1;
    end
    check("wait_finish_in_budget", {63'd0, got}, 64'd1);
  endtask

  initial begin
    int            mask;
    int            fin_at;
    int            p0;
    int            w0;
    logic          changed;
    logic [DL-1:0] b;

    rst_n = 1'b0;
    rd    = 1'b0;
    update_fifo_if();

    // Reset values
    #12;
    check("reset_uart_rd", {63'd0, uart_rd}, 64'd0);
    check("reset_finished", {63'd0, rd_finished}, 64'd0);
    check("reset_buffer", rd_buffer, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic word with latency profile
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    pulse_rd();
    mask   = 0;
    fin_at = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (uart_rd) mask |= (1 << k);
      if (rd_finished && fin_at == 0) fin_at = k;
    end
    check("basic_pop_cycles", mask, 32'hAA);
    check("basic_finish_cycle", fin_at, 9);
    check("basic_word", rd_buffer, 32'h44332211);
    check("basic_finished_held", {63'd0, rd_finished}, 64'd1);

    // Stall mid-word
    push_byte(8'hAA); push_byte(8'hBB);
    pulse_rd();
    repeat (10) tick();
    p0 = pops;
    for (int k = 0; k < 20; k++) tick();
    check("stall_no_pop", pops - p0, 0);
    check("stall_partial", rd_buffer, 32'h0000BBAA);
    check("stall_not_finished", {63'd0, rd_finished}, 64'd0);
    push_byte(8'hCC); push_byte(8'hDD);
    wait_finish(30);
    check("stall_word", rd_buffer, 32'hDDCCBBAA);

    // i_rd ignored mid-word
    for (int k = 0; k < NB; k++) push_byte(DL'($urandom));
    p0 = pops;
    w0 = words;
    pulse_rd();
    repeat (3) tick();
    pulse_rd();
    wait_finish(30);
    repeat (15) tick();
    check("ignore_pops", pops - p0, NB);
    check("ignore_words", words - w0, 1);

    // Back-to-back with i_rd held high
    for (int k = 1; k <= 8; k++) push_byte(DL'(k));
    rd = 1'b1;
    wait_finish(30);
    tick();
    check("b2b_finished_one_cycle", {63'd0, rd_finished}, 64'd0);
    check("b2b_buffer_cleared", rd_buffer, 64'd0);
    wait_finish(30);
    rd = 1'b0;
    check("b2b_second_word", rd_buffer, 32'h08070605);

    // Randomized words with random FIFO gaps
    for (int w = 0; w < 6; w++) begin
      pulse_rd();
      for (int k = 0; k < NB; k++) begin
        repeat ($urandom_range(0, 6)) tick();
        push_byte(DL'($urandom));
      end
      wait_finish(60);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Idle with a non-empty FIFO
    for (int k = 0; k < NB; k++) push_byte(DL'($urandom));
    p0      = pops;
    changed = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (rd_buffer !== last_word || rd_finished !== 1'b1) changed = 1'b1;
    end
    check("idle_no_pop", pops - p0, 0);
    check("idle_outputs_stable", {63'd0, changed}, 64'd0);

    // Asynchronous reset after byte 3
    p0 = pops;
    pulse_rd();
    for (int k = 0; k < 20 && (pops - p0) < 3; k++) tick();
    check("reset_pre_pops", pops - p0, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_uart_rd", {63'd0, uart_rd}, 64'd0);
    check("async_finished", {63'd0, rd_finished}, 64'd0);
    check("async_buffer", rd_buffer, 64'd0);
    fifo_q.delete();
    exp_q.delete();
    prev_uart_rd = 1'b0;
    prev_fin     = 1'b0;
    update_fifo_if();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NB; k++) begin
      b = DL'($urandom);
      push_byte(b);
    end
    p0 = pops;
    repeat (10) tick();
    check("post_reset_no_pop", pops - p0, 0);
    check("post_reset_buffer", rd_buffer, 64'd0);
    pulse_rd();
    wait_finish(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 SHALL have parameter DATA_LEN, default 8, meaning the UART byte width.
REQ-002 SHALL have parameter DATA_OUT_LEN, default 32, meaning the assembled word width; it SHALL be an integer multiple of DATA_LEN (NB = DATA_OUT_LEN/DATA_LEN, 4 by default).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_is_uart_empty, input, 1 bit: UART RX FIFO holds no byte.
REQ-006 SHALL have port i_rd, input, 1 bit: request to assemble one word.
REQ-007 SHALL have port i_rd_data, input, DATA_LEN bits: RX FIFO head byte (show-ahead, valid while i_is_uart_empty=0).
REQ-008 SHALL have port o_uart_rd, output, 1 bit: RX FIFO pop strobe.
REQ-009 SHALL have port o_rd_finished, output, 1 bit: word assembly complete.
REQ-010 SHALL have port o_rd_buffer, output, DATA_OUT_LEN bits: assembled word.

Function
REQ-011 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-012 The FSM SHALL have three states: IDLE, RD_IDLE and RD; byte pointer width SHALL be clog2(NB)+1 bits.
REQ-013 In IDLE with i_rd=1, the block SHALL clear o_rd_finished, clear o_rd_buffer to 0 and go to RD_IDLE; with i_rd=0 it SHALL hold.
REQ-014 In RD_IDLE with pointer<NB and i_is_uart_empty=0, it SHALL load i_rd_data into o_rd_buffer[pointer*DATA_LEN +: DATA_LEN], set o_uart_rd=1 and go to RD.
REQ-015 In RD_IDLE with pointer<NB and i_is_uart_empty=1, it SHALL hold state, pointer, buffer and o_uart_rd=0 for as long as the FIFO stays empty, with no timeout.
REQ-016 In RD, it SHALL clear o_uart_rd, increment the pointer and return to RD_IDLE.
REQ-017 o_uart_rd SHALL be high for exactly one cycle per byte, and never on two consecutive cycles.
REQ-018 In RD_IDLE with pointer==NB, it SHALL set o_rd_finished=1, clear the pointer and go to IDLE.
REQ-019 Byte order SHALL be LSB-first: the first byte received lands in bits [DATA_LEN-1:0].
REQ-020 Latency with the FIFO never empty: i_rd sampled at edge 0, o_uart_rd high after edges 1, 3, 5 and 7, o_rd_finished high after edge 9.
REQ-021 o_rd_finished SHALL stay high, and o_rd_buffer stable, until the next i_rd is accepted in IDLE.
REQ-022 i_rd SHALL be ignored in RD_IDLE and RD.
REQ-023 i_rd held high continuously SHALL start a new word on the cycle after return to IDLE; o_rd_finished is then high for exactly one cycle.
REQ-024 Bits of o_rd_buffer not yet loaded in the current word SHALL read 0.

Reset
REQ-025 While i_reset_n=0, regardless of i_clk, the block SHALL force state=IDLE, pointer=0, o_uart_rd=0, o_rd_finished=0 and o_rd_buffer=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word; after release the block SHALL wait in IDLE for a new i_rd.
REQ-027 The first functional edge SHALL be the first rising i_clk edge after i_reset_n rises.

Verification
REQ-028 Basic: FIFO preloaded with 0x11,0x22,0x33,0x44; pulse i_rd -> 4 single-cycle o_uart_rd pulses; o_rd_buffer=0x44332211; o_rd_finished high 9 cycles after i_rd.
REQ-029 Stall: FIFO empty after 2 bytes (0xAA,0xBB) for 20 cycles, then 0xCC,0xDD -> no o_uart_rd during the stall, o_rd_buffer=0x0000BBAA during the stall, final 0xDDCCBBAA.
REQ-030 Ignore: i_rd pulsed during byte 2 -> no restart, exactly 4 pops, one completed word.
REQ-031 Back-to-back: i_rd held high, FIFO holds 8 bytes 0x01..0x08 -> words 0x04030201 then 0x08070605; o_rd_finished high for exactly 1 cycle between the words; buffer cleared at the second start.
REQ-032 Async reset: i_reset_n pulled low between clock edges after byte 3 -> outputs 0 immediately; after release no o_uart_rd until a new i_rd.
REQ-033 Idle: i_rd=0 with the FIFO non-empty for 50 cycles -> o_uart_rd never asserted, outputs unchanged.
